// File: rtl/dpd_meas.sv
// Digital phase detector for the DPLL bit-sync loop: synchronises and deglitches M_Data,
// qualifies its edges, and measures each edge's phase error against clk_Para with lock detection.
module dpd_meas #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int EDGE_MODE   = 0,
  parameter int DIV_W       = 8,
  parameter int DEAD_ZONE   = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             M_Data,
  input  logic             clk_Para,
  output logic             bothEdge,
  output logic             sign_hou,
  output logic             sign_qian,
  output logic [DIV_W-1:0] err_mag,
  output logic             err_valid,
  output logic             locked
);

  localparam int LAT    = SYNC_STAGES + FILT_LEN + 1;
  localparam int DL_LEN = LAT - 1;
  localparam int CNT_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int LK_W   = $clog2(LOCK_CNT + 1);
  localparam logic [DIV_W-1:0] PH_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   acc;
  logic                   acc_q;
  logic [CNT_W-1:0]       cnt;
  logic                   qual;
  logic [DL_LEN-1:0]      dl;
  logic                   p;
  logic                   p_d;
  logic [DIV_W-1:0]       ph;
  logic [LK_W-1:0]        lk;

  logic                   rise;
  logic                   fall;
  logic                   qual_now;
  logic                   in_phase;
  logic [LK_W-1:0]        lk_inc;

  assign s = sync[SYNC_STAGES-1];
  // The reference delay line matches the data path so p and the edge pulse line up.
  assign p = dl[DL_LEN-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    qual_now = 1'b0;
    rise     = acc & ~acc_q;
    fall     = ~acc & acc_q;
    case (EDGE_MODE)
      1:       qual_now = rise;
      2:       qual_now = fall;
      default: qual_now = rise | fall;
    endcase
    in_phase = (int'(ph) < DEAD_ZONE);
    lk_inc   = (lk == LK_W'(LOCK_CNT)) ? lk : lk + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values;
  // the reset is synchronous and clears every flop, sync chain included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync      <= '0;
      acc       <= 1'b0;
      acc_q     <= 1'b0;
      cnt       <= '0;
      qual      <= 1'b0;
      dl        <= '0;
      p_d       <= 1'b0;
      ph        <= '0;
      lk        <= '0;
      bothEdge  <= 1'b0;
      err_valid <= 1'b0;
      sign_hou  <= 1'b0;
      sign_qian <= 1'b0;
      err_mag   <= '0;
      locked    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], M_Data};

      // Accepted level only follows s after FILT_LEN consecutive differing cycles.
      if (s == acc) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
        acc <= ~acc;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      acc_q <= acc;
      qual  <= qual_now;

      dl  <= {dl[DL_LEN-2:0], clk_Para};
      p_d <= p;
      if (p != p_d) begin
        ph <= '0;
      end else if (ph != PH_MAX) begin
        ph <= ph + 1'b1;
      end

      bothEdge  <= qual;
      err_valid <= qual;
      sign_hou  <= 1'b0;
      sign_qian <= 1'b0;
      // ph and p_d are pre-update here, so a coincident p transition reports the old phase.
      if (qual) begin
        err_mag <= ph;
        if (in_phase) begin
          lk     <= lk_inc;
          locked <= (lk_inc == LK_W'(LOCK_CNT));
        end else begin
          sign_hou  <= ~p_d;
          sign_qian <= p_d;
          lk        <= '0;
          locked    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpd_meas.sv
// Self-checking bench for dpd_meas: a both-edge/8-bit instance and a rising-only/4-bit instance
// share stimulus; expected pulses are queued at drive time and compared when due.
module tb_dpd_meas;

  localparam int L  = 6;
  localparam int DZ = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       M_Data;
  logic       clk_Para;

  logic       be_a, hou_a, qian_a, ev_a, lk_a;
  logic [7:0] mag_a;
  logic       be_b, hou_b, qian_b, ev_b, lk_b;
  logic [3:0] mag_b;

  dpd_meas #(.SYNC_STAGES(2), .FILT_LEN(3), .EDGE_MODE(0), .DIV_W(8),
             .DEAD_ZONE(DZ), .LOCK_CNT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .M_Data(M_Data), .clk_Para(clk_Para),
    .bothEdge(be_a), .sign_hou(hou_a), .sign_qian(qian_a),
    .err_mag(mag_a), .err_valid(ev_a), .locked(lk_a)
  );

  dpd_meas #(.SYNC_STAGES(2), .FILT_LEN(3), .EDGE_MODE(1), .DIV_W(4),
             .DEAD_ZONE(DZ), .LOCK_CNT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .M_Data(M_Data), .clk_Para(clk_Para),
    .bothEdge(be_b), .sign_hou(hou_b), .sign_qian(qian_b),
    .err_mag(mag_b), .err_valid(ev_b), .locked(lk_b)
  );

  typedef struct {
    int cyc;
    int mag;
    bit hou;
    bit qian;
    bit lck;
  } exp_t;

  typedef struct {
    bit para;
    int off;
    int mag;
    bit hou;
    bit qian;
    bit lck;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t tbl[10];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int para_j = 0;
  int lkm_b  = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic cmp_pulse(input string tag, input exp_t e, input logic be, input logic ev,
                           input logic hou, input logic qian, input int mag, input logic lck);
    check($sformatf("%s bothEdge", tag), be, 1);
    check($sformatf("%s err_valid", tag), ev, 1);
    check($sformatf("%s err_mag", tag), mag, e.mag);
    check($sformatf("%s sign_hou", tag), hou, e.hou);
    check($sformatf("%s sign_qian", tag), qian, e.qian);
    check($sformatf("%s locked", tag), lck, e.lck);
  endtask

  // Scoreboard side: a pulse is expected exactly on its queued cycle, nowhere else.
  always @(negedge clk) begin
    if (q_a.size() > 0 && q_a[0].cyc == cyc)
      cmp_pulse("a", q_a.pop_front(), be_a, ev_a, hou_a, qian_a, int'(mag_a), lk_a);
    else if (be_a | ev_a | hou_a | qian_a)
      check("a unexpected pulse", {be_a, ev_a, hou_a, qian_a}, 0);
    if (q_b.size() > 0 && q_b[0].cyc == cyc)
      cmp_pulse("b", q_b.pop_front(), be_b, ev_b, hou_b, qian_b, int'(mag_b), lk_b);
    else if (be_b | ev_b | hou_b | qian_b)
      check("b unexpected pulse", {be_b, ev_b, hou_b, qian_b}, 0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_para(input bit v);
    clk_Para = v;
    para_j   = cyc + 1;
  endtask

  // Cycles from the reference change to the data change, saturated at the 8-bit limit.
  function automatic int model_mag();
    int m;
    m = cyc + 1 - para_j;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic fire(input bit tog, input int mag, input bit hou, input bit qian, input bit lck);
    exp_t e;
    int   mb;
    if (tog) M_Data = ~M_Data;
    e.cyc  = cyc + 1 + L;
    e.mag  = mag;
    e.hou  = hou;
    e.qian = qian;
    e.lck  = lck;
    q_a.push_back(e);
    if (M_Data) begin
      mb = (mag > 15) ? 15 : mag;
      if (mb < DZ) lkm_b = (lkm_b == 4) ? 4 : lkm_b + 1;
      else         lkm_b = 0;
      e.mag = mb;
      e.lck = (lkm_b == 4);
      q_b.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s a bothEdge", tag), be_a, 0);
    check($sformatf("%s a err_valid", tag), ev_a, 0);
    check($sformatf("%s a signs", tag), {hou_a, qian_a}, 0);
    check($sformatf("%s a err_mag", tag), mag_a, 0);
    check($sformatf("%s a locked", tag), lk_a, 0);
    check($sformatf("%s b bothEdge", tag), be_b, 0);
    check($sformatf("%s b err_mag", tag), mag_b, 0);
    check($sformatf("%s b locked", tag), lk_b, 0);
  endtask

  initial begin
    // {clk_Para level, data offset after it, err_mag, sign_hou, sign_qian, locked}
    tbl[0] = '{1, 7, 7, 0, 1, 0};
    tbl[1] = '{0, 7, 7, 1, 0, 0};
    tbl[2] = '{1, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0};
    tbl[4] = '{1, 1, 1, 0, 0, 0};
    tbl[5] = '{0, 1, 1, 0, 0, 1};
    tbl[6] = '{1, 5, 5, 0, 1, 0};
    tbl[7] = '{0, 2, 2, 1, 0, 0};
    tbl[8] = '{1, 1, 1, 0, 0, 0};
    tbl[9] = '{0, 3, 3, 1, 0, 0};

    rst_n    = 1'b0;
    M_Data   = 1'b1;
    clk_Para = 1'b0;
    idle(5);
    check_zero("reset");

    // Release with M_Data already high: one rising pulse L cycles later.
    rst_n  = 1'b1;
    para_j = cyc + 1 - L;
    fire(0, model_mag(), 1, 0, 0);
    idle(14);
    fire(1, model_mag(), 1, 0, 0);
    idle(14);

    // Two-cycle glitch is rejected; a three-cycle pulse yields a rise and a fall.
    M_Data = 1'b1;
    idle(2);
    M_Data = 1'b0;
    idle(14);
    fire(1, model_mag(), 1, 0, 0);
    idle(3);
    fire(1, model_mag(), 1, 0, 0);
    idle(14);

    for (int i = 0; i < 10; i++) begin
      set_para(tbl[i].para);
      idle(tbl[i].off);
      fire(1, tbl[i].mag, tbl[i].hou, tbl[i].qian, tbl[i].lck);
      idle(14);
      check($sformatf("row %0d held err_mag", i), mag_a, tbl[i].mag);
      check($sformatf("row %0d held locked", i), lk_a, tbl[i].lck);
    end

    // Reference held for 40 cycles: the 4-bit instance saturates at 15.
    set_para(1);
    idle(40);
    fire(1, 40, 0, 1, 0);
    idle(14);
    check("sat held b err_mag", mag_b, 15);

    // Much longer hold saturates the 8-bit counter at 255 (falling edge, rising-only ignores it).
    idle(300);
    fire(1, 255, 0, 1, 0);
    idle(14);
    check("sat held a err_mag", mag_a, 255);
    check("sat b ignores fall", mag_b, 15);

    rst_n = 1'b0;
    idle(1);
    check_zero("mid reset");
    lkm_b = 0;
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check_zero("after release");

    check("a queue drained", q_a.size(), 0);
    check("b queue drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
